// File: rtl/l2_pkg.sv
// Shared encodings for the L2 cache controller: MESI states, snoop results and
// commands, tag-array commands, FSM states, and small decode helpers.
package l2_pkg;

    localparam int WAY_W   = 3;
    localparam int N_REQ   = 3;
    localparam int REQ_L1D = 0;
    localparam int REQ_L1I = 1;
    localparam int REQ_SNP = 2;

    typedef enum logic [1:0] {
        MESI_I = 2'b00,
        MESI_S = 2'b01,
        MESI_E = 2'b10,
        MESI_M = 2'b11
    } mesi_e;

    typedef enum logic [1:0] {
        SNP_NOHIT = 2'b00,
        SNP_HIT   = 2'b01,
        SNP_HITM  = 2'b10
    } snp_res_e;

    typedef enum logic [1:0] {
        SCMD_RD  = 2'b00,
        SCMD_WR  = 2'b01,
        SCMD_INV = 2'b10,
        SCMD_RFO = 2'b11
    } snp_cmd_e;

    typedef enum logic [1:0] {
        ACMD_NONE   = 2'b00,
        ACMD_EVICT  = 2'b01,
        ACMD_FILL   = 2'b10,
        ACMD_UPDATE = 2'b11
    } arr_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_EVICT,
        ST_BUSRD,
        ST_FILL,
        ST_UPDATE,
        ST_SNOOP,
        ST_DONE
    } state_e;

    // State installed by a refill: writes own the line, reads share it unless
    // no other cache reported a copy.
    function automatic logic [1:0] fill_state(input logic is_write, input logic [1:0] bus_res);
        if (is_write)
            return MESI_M;
        else if (bus_res == SNP_NOHIT)
            return MESI_E;
        else
            return MESI_S;
    endfunction

    function automatic logic [1:0] snoop_result(input logic hit, input logic [1:0] mesi);
        if (!hit)
            return SNP_NOHIT;
        else if (mesi == MESI_M)
            return SNP_HITM;
        else
            return SNP_HIT;
    endfunction

endpackage

// File: rtl/l2_rr_arbiter.sv
// Request arbiter: snoop always wins, L1D and L1I alternate through a pointer
// that toggles only when an L1 requester is actually accepted.
module l2_rr_arbiter
    import l2_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_accept,
    output logic [N_REQ-1:0] o_gnt
);

    logic r_prefer_l1i;

    always_comb begin
        o_gnt = '0;
        if (i_req[REQ_SNP])
            o_gnt[REQ_SNP] = 1'b1;
        else if (i_req[REQ_L1D] && (!r_prefer_l1i || !i_req[REQ_L1I]))
            o_gnt[REQ_L1D] = 1'b1;
        else if (i_req[REQ_L1I])
            o_gnt[REQ_L1I] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_prefer_l1i <= 1'b0;
        else if (i_accept && (o_gnt[REQ_L1D] || o_gnt[REQ_L1I]))
            r_prefer_l1i <= ~r_prefer_l1i;
    end

endmodule

// File: rtl/l2_cache_ctrl.sv
// L2 cache controller: arbitrates L1D/L1I/snoop requests and sequences tag
// lookup, eviction, bus refill and MESI updates; all outputs are registered.
module l2_cache_ctrl
    import l2_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [2*N_REQ-1:0]      req_cmd,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    output logic [N_REQ-1:0]        req_grant,
    output logic [ADDR_W-1:0]       arr_addr,
    output logic                    arr_lookup,
    input  logic                    arr_hit,
    input  logic [WAY_W-1:0]        arr_way,
    input  logic [1:0]              arr_mesi,
    input  logic                    arr_alloc_evict,
    input  logic [ADDR_W-1:0]       arr_victim_addr,
    output logic [1:0]              arr_cmd,
    output logic [WAY_W-1:0]        arr_way_sel,
    output logic [1:0]              arr_mesi_new,
    output logic                    bus_rd_valid,
    input  logic                    bus_rd_done,
    input  logic [1:0]              bus_snp_res,
    output logic                    snp_rsp_valid,
    output logic [1:0]              snp_result,
    output logic                    inval_valid,
    output logic [ADDR_W-1:0]       inval_addr,
    output logic                    done_valid,
    output logic                    done_hit
);

    state_e              r_state, w_next_state;
    logic                r_snoop, w_snoop;
    logic [1:0]          r_cmd, w_cmd;
    logic                r_hit, w_hit;

    logic [N_REQ-1:0]    r_req_grant, w_req_grant;
    logic [ADDR_W-1:0]   r_arr_addr, w_arr_addr;
    logic                r_arr_lookup, w_arr_lookup;
    logic [1:0]          r_arr_cmd, w_arr_cmd;
    logic [WAY_W-1:0]    r_arr_way_sel, w_arr_way_sel;
    logic [1:0]          r_arr_mesi_new, w_arr_mesi_new;
    logic                r_bus_rd_valid, w_bus_rd_valid;
    logic                r_snp_rsp_valid, w_snp_rsp_valid;
    logic [1:0]          r_snp_result, w_snp_result;
    logic                r_inval_valid, w_inval_valid;
    logic [ADDR_W-1:0]   r_inval_addr, w_inval_addr;
    logic                r_done_valid, w_done_valid;
    logic                r_done_hit, w_done_hit;

    logic [N_REQ-1:0]    w_gnt;
    logic                w_accept;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [1:0]          w_sel_cmd;
    logic                w_l1_write;

    assign w_accept   = (r_state == ST_IDLE) && (|req_valid);
    assign w_l1_write = !r_snoop && (r_cmd == 2'b01);

    l2_rr_arbiter u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (req_valid),
        .i_accept (w_accept),
        .o_gnt    (w_gnt)
    );

    // L1I only ever reads, so its command field is ignored.
    always_comb begin
        w_sel_addr = '0;
        w_sel_cmd  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_cmd  = req_cmd[2*i +: 2];
            end
        end
        if (w_gnt[REQ_L1I])
            w_sel_cmd = 2'b00;
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        w_next_state    = r_state;
        w_snoop         = r_snoop;
        w_cmd           = r_cmd;
        w_hit           = r_hit;
        w_req_grant     = '0;
        w_arr_addr      = r_arr_addr;
        w_arr_lookup    = 1'b0;
        w_arr_cmd       = ACMD_NONE;
        w_arr_way_sel   = r_arr_way_sel;
        w_arr_mesi_new  = MESI_I;
        w_bus_rd_valid  = 1'b0;
        w_snp_rsp_valid = 1'b0;
        w_snp_result    = SNP_NOHIT;
        w_inval_valid   = 1'b0;
        w_inval_addr    = r_inval_addr;
        w_done_valid    = 1'b0;
        w_done_hit      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_LOOKUP;
                    w_req_grant  = w_gnt;
                    w_snoop      = w_gnt[REQ_SNP];
                    w_cmd        = w_sel_cmd;
                    w_arr_addr   = {w_sel_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                    w_arr_lookup = 1'b1;
                end
            end

            // Array responses are only valid in this cycle, so everything the
            // later states need is captured into the output registers here.
            ST_LOOKUP: begin
                w_arr_way_sel = arr_way;
                w_hit         = arr_hit && !r_snoop;
                if (r_snoop) begin
                    w_next_state    = ST_SNOOP;
                    w_snp_rsp_valid = 1'b1;
                    w_snp_result    = snoop_result(arr_hit, arr_mesi);
                    if (arr_hit) begin
                        case (r_cmd)
                            SCMD_RD: begin
                                w_arr_cmd      = ACMD_UPDATE;
                                w_arr_mesi_new = MESI_S;
                            end
                            SCMD_INV, SCMD_RFO: begin
                                w_arr_cmd      = ACMD_UPDATE;
                                w_arr_mesi_new = MESI_I;
                                w_inval_valid  = 1'b1;
                                w_inval_addr   = r_arr_addr;
                            end
                            default: ;
                        endcase
                    end
                end else if (arr_hit) begin
                    w_next_state   = ST_UPDATE;
                    w_arr_cmd      = ACMD_UPDATE;
                    w_arr_mesi_new = w_l1_write ? MESI_M : arr_mesi;
                end else if (arr_alloc_evict) begin
                    w_next_state  = ST_EVICT;
                    w_arr_cmd     = ACMD_EVICT;
                    w_inval_valid = 1'b1;
                    w_inval_addr  = arr_victim_addr;
                end else begin
                    w_next_state   = ST_BUSRD;
                    w_bus_rd_valid = 1'b1;
                end
            end

            ST_EVICT: begin
                w_next_state   = ST_BUSRD;
                w_bus_rd_valid = 1'b1;
            end

            ST_BUSRD: begin
                if (bus_rd_done) begin
                    w_next_state   = ST_FILL;
                    w_arr_cmd      = ACMD_FILL;
                    w_arr_mesi_new = fill_state(w_l1_write, bus_snp_res);
                end else begin
                    w_bus_rd_valid = 1'b1;
                end
            end

            ST_FILL:   w_next_state = ST_DONE;
            ST_UPDATE: w_next_state = ST_DONE;
            ST_SNOOP:  w_next_state = ST_IDLE;

            ST_DONE: begin
                w_next_state = ST_IDLE;
                w_done_valid = 1'b1;
                w_done_hit   = r_hit;
            end

            default: w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_snoop         <= 1'b0;
            r_cmd           <= '0;
            r_hit           <= 1'b0;
            r_req_grant     <= '0;
            r_arr_addr      <= '0;
            r_arr_lookup    <= 1'b0;
            r_arr_cmd       <= '0;
            r_arr_way_sel   <= '0;
            r_arr_mesi_new  <= '0;
            r_bus_rd_valid  <= 1'b0;
            r_snp_rsp_valid <= 1'b0;
            r_snp_result    <= '0;
            r_inval_valid   <= 1'b0;
            r_inval_addr    <= '0;
            r_done_valid    <= 1'b0;
            r_done_hit      <= 1'b0;
        end else begin
            r_snoop         <= w_snoop;
            r_cmd           <= w_cmd;
            r_hit           <= w_hit;
            r_req_grant     <= w_req_grant;
            r_arr_addr      <= w_arr_addr;
            r_arr_lookup    <= w_arr_lookup;
            r_arr_cmd       <= w_arr_cmd;
            r_arr_way_sel   <= w_arr_way_sel;
            r_arr_mesi_new  <= w_arr_mesi_new;
            r_bus_rd_valid  <= w_bus_rd_valid;
            r_snp_rsp_valid <= w_snp_rsp_valid;
            r_snp_result    <= w_snp_result;
            r_inval_valid   <= w_inval_valid;
            r_inval_addr    <= w_inval_addr;
            r_done_valid    <= w_done_valid;
            r_done_hit      <= w_done_hit;
        end
    end

    assign req_grant     = r_req_grant;
    assign arr_addr      = r_arr_addr;
    assign arr_lookup    = r_arr_lookup;
    assign arr_cmd       = r_arr_cmd;
    assign arr_way_sel   = r_arr_way_sel;
    assign arr_mesi_new  = r_arr_mesi_new;
    assign bus_rd_valid  = r_bus_rd_valid;
    assign snp_rsp_valid = r_snp_rsp_valid;
    assign snp_result    = r_snp_result;
    assign inval_valid   = r_inval_valid;
    assign inval_addr    = r_inval_addr;
    assign done_valid    = r_done_valid;
    assign done_hit      = r_done_hit;

endmodule

// File: tb/tb_l2_cache_ctrl.sv
// Directed bench for l2_cache_ctrl: drives requesters, tag array and bus by
// hand and checks each registered output against hand-computed values.
module tb_l2_cache_ctrl;
    import l2_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [5:0]  req_cmd;
    logic [95:0] req_addr;
    logic [2:0]  req_grant;
    logic [31:0] arr_addr;
    logic        arr_lookup;
    logic        arr_hit;
    logic [2:0]  arr_way;
    logic [1:0]  arr_mesi;
    logic        arr_alloc_evict;
    logic [31:0] arr_victim_addr;
    logic [1:0]  arr_cmd;
    logic [2:0]  arr_way_sel;
    logic [1:0]  arr_mesi_new;
    logic        bus_rd_valid;
    logic        bus_rd_done;
    logic [1:0]  bus_snp_res;
    logic        snp_rsp_valid;
    logic [1:0]  snp_result;
    logic        inval_valid;
    logic [31:0] inval_addr;
    logic        done_valid;
    logic        done_hit;

    int n_vec  = 0;
    int n_fail = 0;

    l2_cache_ctrl #(.ADDR_W(32), .OFFSET_W(6)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_cmd         (req_cmd),
        .req_addr        (req_addr),
        .req_grant       (req_grant),
        .arr_addr        (arr_addr),
        .arr_lookup      (arr_lookup),
        .arr_hit         (arr_hit),
        .arr_way         (arr_way),
        .arr_mesi        (arr_mesi),
        .arr_alloc_evict (arr_alloc_evict),
        .arr_victim_addr (arr_victim_addr),
        .arr_cmd         (arr_cmd),
        .arr_way_sel     (arr_way_sel),
        .arr_mesi_new    (arr_mesi_new),
        .bus_rd_valid    (bus_rd_valid),
        .bus_rd_done     (bus_rd_done),
        .bus_snp_res     (bus_snp_res),
        .snp_rsp_valid   (snp_rsp_valid),
        .snp_result      (snp_result),
        .inval_valid     (inval_valid),
        .inval_addr      (inval_addr),
        .done_valid      (done_valid),
        .done_hit        (done_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic [1:0] cmd, input logic [31:0] addr);
        req_valid[idx]         = 1'b1;
        req_cmd[2*idx +: 2]    = cmd;
        req_addr[idx*32 +: 32] = addr;
    endtask

    task automatic set_arr(input logic hit, input logic [2:0] way, input logic [1:0] mesi,
                           input logic evict, input logic [31:0] victim);
        arr_hit         = hit;
        arr_way         = way;
        arr_mesi        = mesi;
        arr_alloc_evict = evict;
        arr_victim_addr = victim;
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = '0;
        req_cmd     = '0;
        req_addr    = '0;
        bus_rd_done = 1'b0;
        bus_snp_res = '0;
        set_arr(1'b0, 3'd0, MESI_I, 1'b0, '0);
        tick();
        tick();
        check("rst_grant",   32'(req_grant), 0);
        check("rst_busrd",   32'(bus_rd_valid), 0);
        check("rst_arr_cmd", 32'(arr_cmd), 0);
        check("rst_done",    32'(done_valid), 0);
        rst_n = 1'b1;
        tick();
        check("idle_no_grant", 32'(req_grant), 0);

        // L1D read miss into an empty set, refilled Exclusive
        set_req(0, 2'b00, 32'h0000_1040);
        tick();
        check("s1_grant",    32'(req_grant), 'h1);
        check("s1_lookup",   32'(arr_lookup), 1);
        check("s1_arr_addr", arr_addr, 'h1040);
        req_valid = '0;
        set_arr(1'b0, 3'd3, MESI_I, 1'b0, '0);
        tick();
        check("s1_busrd",      32'(bus_rd_valid), 1);
        check("s1_lookup_off", 32'(arr_lookup), 0);
        check("s1_grant_off",  32'(req_grant), 0);
        tick();
        check("s1_busrd_hold", 32'(bus_rd_valid), 1);
        bus_rd_done = 1'b1;
        bus_snp_res = SNP_NOHIT;
        tick();
        check("s1_busrd_drop", 32'(bus_rd_valid), 0);
        check("s1_fill_cmd",   32'(arr_cmd), 2);
        check("s1_fill_mesi",  32'(arr_mesi_new), 2);
        check("s1_fill_way",   32'(arr_way_sel), 3);
        bus_rd_done = 1'b0;
        tick();
        check("s1_done_early", 32'(done_valid), 0);
        tick();
        check("s1_done",     32'(done_valid), 1);
        check("s1_done_hit", 32'(done_hit), 0);

        // same read again hits: done 3 cycles after grant, no bus traffic
        set_req(0, 2'b00, 32'h0000_1040);
        tick();
        check("s2_grant", 32'(req_grant), 'h1);
        req_valid = '0;
        set_arr(1'b1, 3'd3, MESI_E, 1'b0, '0);
        tick();
        check("s2_upd_cmd",  32'(arr_cmd), 3);
        check("s2_upd_mesi", 32'(arr_mesi_new), 2);
        check("s2_busrd_a",  32'(bus_rd_valid), 0);
        tick();
        check("s2_done_early", 32'(done_valid), 0);
        check("s2_busrd_b",    32'(bus_rd_valid), 0);
        tick();
        check("s2_done",     32'(done_valid), 1);
        check("s2_done_hit", 32'(done_hit), 1);

        // L1D and L1I together twice, then snoop joins and wins
        set_req(0, 2'b00, 32'h0000_2000);
        set_req(1, 2'b00, 32'h0000_3000);
        set_arr(1'b1, 3'd1, MESI_S, 1'b0, '0);
        tick();
        check("s3_grant_l1d", 32'(req_grant), 'h1);
        check("s3_addr_l1d",  arr_addr, 'h2000);
        tick();
        tick();
        tick();
        check("s3_done_a", 32'(done_valid), 1);
        tick();
        check("s3_grant_l1i", 32'(req_grant), 'h2);
        check("s3_addr_l1i",  arr_addr, 'h3000);
        set_req(2, SCMD_RD, 32'h0000_4000);
        tick();
        check("s3_wait_grant", 32'(req_grant), 0);
        tick();
        tick();
        tick();
        check("s3_grant_snp", 32'(req_grant), 'h4);
        check("s3_addr_snp",  arr_addr, 'h4000);
        req_valid = '0;
        set_arr(1'b0, 3'd0, MESI_I, 1'b0, '0);
        tick();
        check("s3_snp_rsp",  32'(snp_rsp_valid), 1);
        check("s3_snp_res",  32'(snp_result), 0);
        check("s3_snp_cmd",  32'(arr_cmd), 0);
        tick();
        check("s3_snp_rsp_off", 32'(snp_rsp_valid), 0);

        // L1D write miss into a full set: evict, refill, install Modified
        set_req(0, 2'b01, 32'h0000_5080);
        tick();
        check("s4_grant", 32'(req_grant), 'h1);
        check("s4_addr",  arr_addr, 'h5080);
        req_valid = '0;
        set_arr(1'b0, 3'd5, MESI_I, 1'b1, 32'h0000_9AC0);
        tick();
        check("s4_evict_cmd", 32'(arr_cmd), 1);
        check("s4_inval",     32'(inval_valid), 1);
        check("s4_inval_adr", inval_addr, 'h9AC0);
        check("s4_way",       32'(arr_way_sel), 5);
        check("s4_no_busrd",  32'(bus_rd_valid), 0);
        tick();
        check("s4_busrd",     32'(bus_rd_valid), 1);
        check("s4_inval_off", 32'(inval_valid), 0);
        check("s4_cmd_off",   32'(arr_cmd), 0);
        bus_rd_done = 1'b1;
        bus_snp_res = SNP_HIT;
        tick();
        check("s4_fill_cmd",  32'(arr_cmd), 2);
        check("s4_fill_mesi", 32'(arr_mesi_new), 3);
        bus_rd_done = 1'b0;
        tick();
        tick();
        check("s4_done",     32'(done_valid), 1);
        check("s4_done_hit", 32'(done_hit), 0);

        // snoop RFO hitting a Modified line
        set_req(2, SCMD_RFO, 32'h0000_1047);
        tick();
        check("s5_grant", 32'(req_grant), 'h4);
        check("s5_addr",  arr_addr, 'h1040);
        req_valid = '0;
        set_arr(1'b1, 3'd3, MESI_M, 1'b0, '0);
        tick();
        check("s5_snp_rsp",   32'(snp_rsp_valid), 1);
        check("s5_snp_res",   32'(snp_result), 2);
        check("s5_cmd",       32'(arr_cmd), 3);
        check("s5_mesi",      32'(arr_mesi_new), 0);
        check("s5_inval",     32'(inval_valid), 1);
        check("s5_inval_adr", inval_addr, 'h1040);
        tick();
        check("s5_snp_off",   32'(snp_rsp_valid), 0);
        check("s5_inval_off", 32'(inval_valid), 0);

        // snoop arriving during a refill is served before the waiting L1D
        set_req(1, 2'b00, 32'h0000_7000);
        tick();
        check("s6_grant_l1i", 32'(req_grant), 'h2);
        req_valid = '0;
        set_arr(1'b0, 3'd2, MESI_I, 1'b0, '0);
        tick();
        check("s6_busrd", 32'(bus_rd_valid), 1);
        set_req(2, SCMD_RD, 32'h0000_8000);
        set_req(0, 2'b00, 32'h0000_6000);
        tick();
        check("s6_hold_grant", 32'(req_grant), 0);
        check("s6_busrd_hold", 32'(bus_rd_valid), 1);
        bus_rd_done = 1'b1;
        bus_snp_res = SNP_HITM;
        tick();
        check("s6_fill_cmd",  32'(arr_cmd), 2);
        check("s6_fill_mesi", 32'(arr_mesi_new), 1);
        bus_rd_done = 1'b0;
        tick();
        tick();
        check("s6_done", 32'(done_valid), 1);
        set_arr(1'b1, 3'd4, MESI_E, 1'b0, '0);
        tick();
        check("s6_grant_snp", 32'(req_grant), 'h4);
        check("s6_addr_snp",  arr_addr, 'h8000);
        req_valid[2] = 1'b0;
        tick();
        check("s6_snp_res",   32'(snp_result), 1);
        check("s6_snp_cmd",   32'(arr_cmd), 3);
        check("s6_snp_mesi",  32'(arr_mesi_new), 1);
        check("s6_snp_noinv", 32'(inval_valid), 0);
        set_arr(1'b0, 3'd6, MESI_I, 1'b0, '0);
        tick();
        tick();
        check("s6_grant_l1d", 32'(req_grant), 'h1);
        check("s6_addr_l1d",  arr_addr, 'h6000);
        req_valid = '0;
        tick();
        check("s6_busrd_b", 32'(bus_rd_valid), 1);

        // reset in the middle of the refill
        rst_n = 1'b0;
        tick();
        check("r_busrd",   32'(bus_rd_valid), 0);
        check("r_addr",    arr_addr, 0);
        check("r_way_sel", 32'(arr_way_sel), 0);
        check("r_cmd",     32'(arr_cmd), 0);
        check("r_grant",   32'(req_grant), 0);
        check("r_snp",     32'(snp_rsp_valid), 0);
        rst_n = 1'b1;
        set_req(0, 2'b00, 32'h0000_1000);
        set_req(1, 2'b00, 32'h0000_2000);
        tick();
        check("r_grant_l1d", 32'(req_grant), 'h1);
        check("r_addr_l1d",  arr_addr, 'h1000);
        req_valid = '0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/l2_cache_ctrl.md
L2_CACHE_CTRL -- requirements
Module: l2_cache_ctrl

Interface
REQ-001 The block SHALL use one clock, clk; reset rst_n SHALL be synchronous and active-low.
REQ-002 Parameters SHALL be:
  - ADDR_W, default 32, address width.
  - OFFSET_W, default 6, line offset bits.
REQ-003 Ports SHALL be as follows (requester index: 0=L1D, 1=L1I, 2=snoop):
  - clk  in  1  clock
  - rst_n  in  1  sync active-low reset
  - req_valid  in  3  request pending, per requester
  - req_cmd  in  6  2 bits per requester; L1D 00 read/01 write; L1I 00 read; snoop 00 read/01 write/10 invalidate/11 RFO
  - req_addr  in  3*ADDR_W  address per requester
  - req_grant  out  3  one-hot, one-cycle accept pulse
  - arr_addr  out  ADDR_W  latched request address, offset zeroed
  - arr_lookup  out  1  tag lookup strobe
  - arr_hit  in  1  lookup hit (combinational, same cycle)
  - arr_way  in  3  hit way, else empty way, else LRU way
  - arr_mesi  in  2  MESI of hit way
  - arr_alloc_evict  in  1  miss with no empty way
  - arr_victim_addr  in  ADDR_W  line address in arr_way
  - arr_cmd  out  2  00 none, 01 evict, 10 fill, 11 update
  - arr_way_sel  out  3  way for arr_cmd
  - arr_mesi_new  out  2  state written by fill/update
  - bus_rd_valid  out  1  line read to memory, address arr_addr
  - bus_rd_done  in  1  bus read complete
  - bus_snp_res  in  2  snoop result of other caches at bus_rd_done
  - snp_rsp_valid  out  1  snoop result pulse
  - snp_result  out  2  NOHIT/HIT/HITM
  - inval_valid  out  1  L1 invalidate pulse
  - inval_addr  out  ADDR_W  address to invalidate in L1
  - done_valid  out  1  L1 request completion pulse
  - done_hit  out  1  completed request was a hit

Function
REQ-004 The FSM SHALL use states IDLE, LOOKUP, EVICT, BUSRD, FILL, UPDATE, SNOOP, DONE.
REQ-005 In IDLE with any req_valid, the block SHALL grant snoop first, else round-robin L1D/L1I, latch cmd/addr, pulse req_grant, and go to LOOKUP.
  - The round-robin pointer SHALL toggle only on an L1 grant.
REQ-006 LOOKUP SHALL pulse arr_lookup for one cycle and branch:
  - snoop -> SNOOP
  - hit -> UPDATE
  - miss with arr_alloc_evict=1 -> EVICT
  - miss with arr_alloc_evict=0 -> BUSRD
  - arr_way SHALL be latched as the working way.
REQ-007 EVICT SHALL, for one cycle, issue arr_cmd=01 and inval_valid with inval_addr=arr_victim_addr, then go to BUSRD.
REQ-008 BUSRD SHALL hold bus_rd_valid high until bus_rd_done, latch bus_snp_res, then go to FILL.
  - bus_rd_valid SHALL drop on the cycle after bus_rd_done.
REQ-009 FILL SHALL issue arr_cmd=10, then go to DONE.
  - arr_mesi_new: write -> M; read with result NOHIT -> E; read otherwise -> S.
REQ-010 UPDATE SHALL issue arr_cmd=11 (LRU update), then go to DONE.
  - arr_mesi_new: write -> M; read -> arr_mesi unchanged.
REQ-011 DONE SHALL pulse done_valid, with done_hit=1 only via the UPDATE path, then go to IDLE.
REQ-012 SNOOP SHALL pulse snp_rsp_valid, then go to IDLE.
  - snp_result: miss -> NOHIT; hit in M -> HITM; other hit -> HIT.
  - Read hit: arr_cmd=11, M/E -> S.
  - Invalidate or RFO hit: arr_cmd=11, -> I, plus inval_valid with inval_addr=arr_addr.
  - Write: no state change.
REQ-013 Read-hit latency SHALL be done_valid 3 cycles after req_grant; a miss without evict SHALL be 3 cycles after bus_rd_done.
REQ-014 Requests arriving outside IDLE SHALL wait.
  - A snoop arriving during BUSRD SHALL be served after DONE, ahead of pending L1 requests.

Reset
REQ-015 With rst_n low at an edge, the block SHALL clear all outputs, force state IDLE, and point round-robin at L1D.
  - This SHALL apply mid-operation; bus_rd_valid SHALL be low the next cycle.

Structure
REQ-016 Package l2_pkg SHALL hold the MESI, snoop-result, snoop-cmd and arr_cmd encodings, the FSM state enum, and WAY_W=3.
REQ-017 Sub-module l2_rr_arbiter SHALL implement the snoop-priority/L1 round-robin grant.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
  - L1D read 0x00001040 into an empty set, bus_snp_res=NOHIT -> bus_rd_valid, fill with E, done_hit=0.
  - Repeat that read -> done_hit=1, 3 cycles after grant, no bus activity.
  - L1D and L1I valid together, twice -> grants L1D then L1I; with snoop also valid, snoop first.
  - Full set miss -> EVICT with inval_addr=arr_victim_addr, then BUSRD, then FILL.
  - Snoop RFO on an M line -> snp_result=HITM, state I, inval_valid.
  - rst_n low during BUSRD -> next cycle bus_rd_valid=0, state IDLE, outputs zero.
